// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and register typedefs for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NRD_DEF   = 2;
    localparam int unsigned NWR_DEF   = 1;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return (nregs < 2) ? 1 : $clog2(nregs);
    endfunction

    localparam int unsigned AW_DEF = addr_width(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_if.sv
// Read/write/reserve bus of the register file; master drives requests, slave returns read data.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = NRD_DEF,
    parameter int unsigned NWR   = NWR_DEF
);
    localparam int unsigned AW = addr_width(NREGS);

    logic [NRD-1:0]           rd_en;
    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic                     flush;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write busy bits: flush beats reserve, reserve beats a same-cycle write clear; x0 never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = NWR_DEF,
    parameter int unsigned AW    = addr_width(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rsv_en,
    input  logic [AW-1:0]          i_rsv_addr,
    input  logic                   i_flush,
    input  logic [NWR-1:0]         i_wr_en,
    input  logic [NWR-1:0][AW-1:0] i_wr_addr,
    output logic [NREGS-1:0]       o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned i = 1; i < NREGS; i++) begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w] == AW'(i)))
                    w_busy_nxt[i] = 1'b0;
            end
            // Applied after the clear so a same-cycle reserve survives the write.
            if (i_rsv_en && (i_rsv_addr == AW'(i)))
                w_busy_nxt[i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads and pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = NRD_DEF,
    parameter int unsigned NWR   = NWR_DEF
) (
    input logic       clk,
    input logic       rst,
    regfile_if.slave  bus
);

    localparam int unsigned AW = addr_width(NREGS);

    logic [XLEN-1:0]          r_regs [NREGS];
    logic [NRD-1:0][XLEN-1:0] r_rd_data;
    logic [NRD-1:0]           r_rd_busy;
    logic [NREGS-1:0]         w_busy;
    logic [NRD-1:0][XLEN-1:0] w_rd_data;
    logic [NRD-1:0]           w_rd_busy;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_rsv_en   (bus.rsv_en),
        .i_rsv_addr (bus.rsv_addr),
        .i_flush    (bus.flush),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .o_busy     (w_busy)
    );

    // Ascending port loop: the highest-indexed writer to an address wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && (bus.wr_addr[w] != '0))
                    r_regs[bus.wr_addr[w]] <= bus.wr_data[w];
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NRD; p++) begin
            w_rd_data[p] = (bus.rd_addr[p] == '0) ? '0 : r_regs[bus.rd_addr[p]];
            w_rd_busy[p] = w_busy[bus.rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[p]) && (bus.rd_addr[p] != '0)) begin
                    w_rd_data[p] = bus.wr_data[w];
                    w_rd_busy[p] = bus.rsv_en && (bus.rsv_addr == bus.rd_addr[p]);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_rd_busy <= '0;
        end else begin
            for (int unsigned p = 0; p < NRD; p++) begin
                if (bus.rd_en[p]) begin
                    r_rd_data[p] <= w_rd_data[p];
                    r_rd_busy[p] <= w_rd_busy[p];
                end
            end
        end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.rd_busy = r_rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (two read, two write ports).
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic idle();
        bus.rd_en    = '0;
        bus.rd_addr  = '0;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.rd_en = 2'b11;
        bus.rd_addr[0] = 5'd1;
        bus.rd_addr[1] = 5'd2;
        tick();
        tick();
        n_tests++;
        if (bus.rd_data[0] !== 32'h0 || bus.rd_data[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h expected 0/0", bus.rd_data[0], bus.rd_data[1]);
        end
        n_tests++;
        if (bus.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 00", bus.rd_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        bus.wr_en[0] = 1'b1;
        bus.wr_addr[0] = 5'd5;
        bus.wr_data[0] = 32'hDEADBEEF;
        tick();
        bus.rd_en = 2'b11;
        bus.rd_addr[0] = 5'd5;
        bus.rd_addr[1] = 5'd5;
        tick();
        n_tests++;
        if (bus.rd_data[0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_read_p0: got %h expected deadbeef", bus.rd_data[0]);
        end
        n_tests++;
        if (bus.rd_data[1] !== 32'hDEADBEEF || bus.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL write_read_p1: got %h busy %b expected deadbeef busy 00", bus.rd_data[1], bus.rd_busy);
        end
        // rd_en low: outputs hold even though the address changes
        bus.rd_addr[0] = 5'd6;
        tick();
        n_tests++;
        if (bus.rd_data[0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL read_hold: got %h expected deadbeef", bus.rd_data[0]);
        end
    endtask

    task automatic test_x0();
        bus.wr_en[0] = 1'b1;
        bus.wr_addr[0] = 5'd0;
        bus.wr_data[0] = 32'h1234;
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd0;
        tick();
        bus.rd_en[0] = 1'b1;
        bus.rd_addr[0] = 5'd0;
        tick();
        n_tests++;
        if (bus.rd_data[0] !== 32'h0 || bus.rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_read: got %h busy %b expected 0 busy 0", bus.rd_data[0], bus.rd_busy[0]);
        end
    endtask

    task automatic test_dual_write();
        bus.wr_en = 2'b11;
        bus.wr_addr[0] = 5'd7;
        bus.wr_addr[1] = 5'd7;
        bus.wr_data[0] = 32'h11;
        bus.wr_data[1] = 32'h22;
        tick();
        bus.wr_en = 2'b11;
        bus.wr_addr[0] = 5'd8;
        bus.wr_addr[1] = 5'd10;
        bus.wr_data[0] = 32'h33;
        bus.wr_data[1] = 32'h44;
        bus.rd_en[0] = 1'b1;
        bus.rd_addr[0] = 5'd7;
        tick();
        n_tests++;
        if (bus.rd_data[0] !== 32'h22) begin
            n_fail++;
            $display("FAIL dual_write_same: got %h expected 00000022", bus.rd_data[0]);
        end
        bus.rd_en = 2'b11;
        bus.rd_addr[0] = 5'd8;
        bus.rd_addr[1] = 5'd10;
        tick();
        n_tests++;
        if (bus.rd_data[0] !== 32'h33 || bus.rd_data[1] !== 32'h44) begin
            n_fail++;
            $display("FAIL dual_write_diff: got %h/%h expected 33/44", bus.rd_data[0], bus.rd_data[1]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_data;
`ifdef REGFILE_BYPASS_EN
        exp_data = 32'hA5;
`else
        exp_data = 32'h0;
`endif
        bus.wr_en[0] = 1'b1;
        bus.wr_addr[0] = 5'd3;
        bus.wr_data[0] = 32'hA5;
        bus.rd_en[0] = 1'b1;
        bus.rd_addr[0] = 5'd3;
        tick();
        n_tests++;
        if (bus.rd_data[0] !== exp_data || bus.rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_read: got %h busy %b expected %h busy 0", bus.rd_data[0], bus.rd_busy[0], exp_data);
        end
        bus.rd_en[0] = 1'b1;
        bus.rd_addr[0] = 5'd3;
        tick();
        n_tests++;
        if (bus.rd_data[0] !== 32'hA5) begin
            n_fail++;
            $display("FAIL bypass_after: got %h expected 000000a5", bus.rd_data[0]);
        end
    endtask

    task automatic test_scoreboard();
        // read during the reserve edge sees the pre-edge (clear) busy bit
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd9;
        bus.rd_en[1] = 1'b1;
        bus.rd_addr[1] = 5'd9;
        tick();
        n_tests++;
        if (bus.rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_pre_edge: got %b expected 0", bus.rd_busy[1]);
        end
        bus.rd_en[0] = 1'b1;
        bus.rd_addr[0] = 5'd9;
        tick();
        n_tests++;
        if (bus.rd_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_set: got %b expected 1", bus.rd_busy[0]);
        end
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd9;
        bus.wr_en[1] = 1'b1;
        bus.wr_addr[1] = 5'd9;
        bus.wr_data[1] = 32'h99;
        tick();
        bus.rd_en[0] = 1'b1;
        bus.rd_addr[0] = 5'd9;
        tick();
        n_tests++;
        if (bus.rd_busy[0] !== 1'b1 || bus.rd_data[0] !== 32'h99) begin
            n_fail++;
            $display("FAIL rsv_wins: got busy %b data %h expected busy 1 data 99", bus.rd_busy[0], bus.rd_data[0]);
        end
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd11;
        tick();
        bus.wr_en[0] = 1'b1;
        bus.wr_addr[0] = 5'd11;
        bus.wr_data[0] = 32'hBB;
        tick();
        bus.rd_en[0] = 1'b1;
        bus.rd_addr[0] = 5'd11;
        tick();
        n_tests++;
        if (bus.rd_busy[0] !== 1'b0 || bus.rd_data[0] !== 32'hBB) begin
            n_fail++;
            $display("FAIL write_clears: got busy %b data %h expected busy 0 data bb", bus.rd_busy[0], bus.rd_data[0]);
        end
        // flush together with a reserve of a fresh register
        bus.flush = 1'b1;
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd12;
        tick();
        bus.rd_en = 2'b11;
        bus.rd_addr[0] = 5'd9;
        bus.rd_addr[1] = 5'd12;
        tick();
        n_tests++;
        if (bus.rd_busy !== 2'b00 || bus.rd_data[0] !== 32'h99) begin
            n_fail++;
            $display("FAIL flush: got busy %b data %h expected busy 00 data 99", bus.rd_busy, bus.rd_data[0]);
        end
    endtask

    task automatic test_reset_override();
        bus.rsv_en = 1'b1;
        bus.rsv_addr = 5'd13;
        tick();
        rst = 1'b1;
        bus.wr_en[0] = 1'b1;
        bus.wr_addr[0] = 5'd4;
        bus.wr_data[0] = 32'h55;
        bus.rd_en = 2'b11;
        bus.rd_addr[0] = 5'd5;
        bus.rd_addr[1] = 5'd13;
        tick();
        n_tests++;
        if (bus.rd_data !== '0 || bus.rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h busy %b expected 0 busy 00", bus.rd_data, bus.rd_busy);
        end
        rst = 1'b0;
        bus.rd_en = 2'b11;
        bus.rd_addr[0] = 5'd4;
        bus.rd_addr[1] = 5'd13;
        tick();
        n_tests++;
        if (bus.rd_data[0] !== 32'h0 || bus.rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_override_x4: got %h busy %b expected 0 busy 0", bus.rd_data[0], bus.rd_busy[1]);
        end
        bus.rd_en[0] = 1'b1;
        bus.rd_addr[0] = 5'd5;
        tick();
        n_tests++;
        if (bus.rd_data[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_clears_x5: got %h expected 0", bus.rd_data[0]);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_x0();
        test_dual_write();
        test_bypass();
        test_scoreboard();
        test_reset_override();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
